// File: rtl/asfifox_mvb_packer_pkg.sv
// asfifox_mvb_packer_pkg: shared defaults, item type and width helper for the MVB packer
package asfifox_mvb_packer_pkg;
  localparam int DEF_MVB_ITEMS = 4;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_TIMEOUT = 16;
  typedef logic [DEF_DATA_WIDTH-1:0] item_t;
  // ceil(log2(n)), never below 1 so zero-range counters still get one bit
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/asfifox_mvb_packer_timer.sv
// mvb_pack_timer: saturating idle counter; expired once it reaches TIMEOUT, never when TIMEOUT=0
module mvb_pack_timer
  import asfifox_mvb_packer_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
)(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int TW = log2(TIMEOUT + 1);
  localparam logic [TW-1:0] SAT = TW'(TIMEOUT);
  logic [TW-1:0] t;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) t <= '0;
    else if (clr) t <= '0;
    else if (en && t != SAT) t <= t + 1'b1;
  assign expired = TIMEOUT > 0 && t == SAT;
endmodule

// File: rtl/asfifox_mvb_packer.sv
// asfifox_mvb_packer: packs FWFT FIFO items into MVB words, flushing partials on idle timeout or flush
module asfifox_mvb_packer
  import asfifox_mvb_packer_pkg::*;
#(
  parameter int MVB_ITEMS  = DEF_MVB_ITEMS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
)(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           rd_data,
  input  logic                            rd_empty,
  output logic                            rd_en,
  input  logic                            flush,
  output logic [MVB_ITEMS*DATA_WIDTH-1:0] tx_data,
  output logic [MVB_ITEMS-1:0]            tx_vld,
  output logic                            tx_src_rdy,
  input  logic                            tx_dst_rdy
);
  localparam int CW = log2(MVB_ITEMS + 1);
  localparam logic [CW-1:0] FULL = CW'(MVB_ITEMS);
  logic [CW-1:0] cnt;
  logic [MVB_ITEMS*DATA_WIDTH-1:0] acc_data;
  logic [MVB_ITEMS-1:0] vld_n;
  logic acc, freq, move, expired;
  assign freq = cnt == FULL || (cnt != '0 && (flush || expired));
  assign move = freq && (!tx_src_rdy || tx_dst_rdy);
  assign rd_en = rst_n && (cnt < FULL || move);
  assign acc = rd_en && !rd_empty;
  always_comb begin
    vld_n = '0;
    for (int i = 0; i < MVB_ITEMS; i++) vld_n[i] = CW'(i) < cnt;
  end
  mvb_pack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk,
    .rst_n,
    .clr(acc || move || cnt == '0),
    .en(cnt != '0),
    .expired
  );
  // an item accepted during a move starts the next word, never joins the flushed one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt        <= '0;
      acc_data   <= '0;
      tx_data    <= '0;
      tx_vld     <= '0;
      tx_src_rdy <= 1'b0;
    end else if (move) begin
      tx_data    <= acc_data;
      tx_vld     <= vld_n;
      tx_src_rdy <= 1'b1;
      acc_data   <= acc ? (MVB_ITEMS*DATA_WIDTH)'(rd_data) : '0;
      cnt        <= acc ? CW'(1) : '0;
    end else begin
      if (tx_dst_rdy) tx_src_rdy <= 1'b0;
      if (acc) begin
        for (int i = 0; i < MVB_ITEMS; i++)
          if (cnt == CW'(i)) acc_data[i*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
        cnt <= cnt + 1'b1;
      end
    end
endmodule
